// File: rtl/wallace_pkg.sv
// Shared widths and types for the 8x8 Wallace-tree multiplier.
package wallace_pkg;
  localparam int MUL_W  = 8;
  localparam int PROD_W = 16;

  typedef logic [MUL_W-1:0]  operand_t;
  typedef logic [PROD_W-1:0] product_t;
endpackage

// File: rtl/wallace_multiplier_csa_fa.sv
// csa_fa: 1-bit full adder used as the 3:2 compressor of the reduction tree.
module csa_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

// File: rtl/wallace_multiplier.sv
// Unsigned 8x8 -> 16 Wallace-tree multiplier with registered result.
// Optional WALLACE_PIPE_EN registers the two-row tree output, adding one cycle of latency.
module wallace_multiplier
  import wallace_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     in_valid,
  input  operand_t a,
  input  operand_t b,
  output product_t result,
  output logic     out_valid
);
  // Valid semantics: in_valid qualifies a/b every cycle, there is no ready (always
  // accepted); out_valid marks the cycle result was loaded, result holds otherwise.

  logic [MUL_W-1:0][PROD_W-1:0] pp;

  for (genvar i = 0; i < MUL_W; i++) begin : g_pp
    assign pp[i] = {8'b0, a & {MUL_W{b[i]}}} << i;
  end

  // Reduction is done row-wise: each 3:2 group yields a sum row and a carry row
  // shifted by one. A carry out of bit 15 cannot occur because the total fits 16 bits.

  // Stage 1: 8 -> 6 (two full-adder groups, half adders on rows 6/7)
  logic [5:0][PROD_W-1:0] st1;
  logic [1:0][PROD_W-2:0] cy1;
  logic [PROD_W-2:0]      ha_c;

  for (genvar g = 0; g < 2; g++) begin : g_st1
    for (genvar k = 0; k < PROD_W-1; k++) begin : g_bit
      csa_fa u_fa (
        .a_i(pp[3*g][k]), .b_i(pp[3*g+1][k]), .c_i(pp[3*g+2][k]),
        .s_o(st1[2*g][k]), .c_o(cy1[g][k])
      );
    end
    assign st1[2*g][PROD_W-1] = pp[3*g][PROD_W-1] ^ pp[3*g+1][PROD_W-1] ^ pp[3*g+2][PROD_W-1];
    assign st1[2*g+1]         = {cy1[g], 1'b0};
  end

  assign ha_c   = pp[6][PROD_W-2:0] & pp[7][PROD_W-2:0];
  assign st1[4] = pp[6] ^ pp[7];
  assign st1[5] = {ha_c, 1'b0};

  // Stage 2: 6 -> 4
  logic [3:0][PROD_W-1:0] st2;
  logic [1:0][PROD_W-2:0] cy2;

  for (genvar g = 0; g < 2; g++) begin : g_st2
    for (genvar k = 0; k < PROD_W-1; k++) begin : g_bit
      csa_fa u_fa (
        .a_i(st1[3*g][k]), .b_i(st1[3*g+1][k]), .c_i(st1[3*g+2][k]),
        .s_o(st2[2*g][k]), .c_o(cy2[g][k])
      );
    end
    assign st2[2*g][PROD_W-1] = st1[3*g][PROD_W-1] ^ st1[3*g+1][PROD_W-1] ^ st1[3*g+2][PROD_W-1];
    assign st2[2*g+1]         = {cy2[g], 1'b0};
  end

  // Stage 3: 4 -> 3 (row 3 passes through)
  logic [2:0][PROD_W-1:0] st3;
  logic [PROD_W-2:0]      cy3;

  for (genvar k = 0; k < PROD_W-1; k++) begin : g_st3
    csa_fa u_fa (
      .a_i(st2[0][k]), .b_i(st2[1][k]), .c_i(st2[2][k]),
      .s_o(st3[0][k]), .c_o(cy3[k])
    );
  end
  assign st3[0][PROD_W-1] = st2[0][PROD_W-1] ^ st2[1][PROD_W-1] ^ st2[2][PROD_W-1];
  assign st3[1]           = {cy3, 1'b0};
  assign st3[2]           = st2[3];

  // Stage 4: 3 -> 2
  logic [1:0][PROD_W-1:0] st4;
  logic [PROD_W-2:0]      cy4;

  for (genvar k = 0; k < PROD_W-1; k++) begin : g_st4
    csa_fa u_fa (
      .a_i(st3[0][k]), .b_i(st3[1][k]), .c_i(st3[2][k]),
      .s_o(st4[0][k]), .c_o(cy4[k])
    );
  end
  assign st4[0][PROD_W-1] = st3[0][PROD_W-1] ^ st3[1][PROD_W-1] ^ st3[2][PROD_W-1];
  assign st4[1]           = {cy4, 1'b0};

  product_t sum_row;
  product_t carry_row;
  logic     add_valid;

`ifdef WALLACE_PIPE_EN
  product_t sum_q, sum_d;
  product_t carry_q, carry_d;
  logic     pvld_q, pvld_d;

  always_comb begin
    sum_d   = sum_q;
    carry_d = carry_q;
    pvld_d  = in_valid;
    if (in_valid) begin
      sum_d   = st4[0];
      carry_d = st4[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      carry_q <= '0;
      pvld_q  <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      pvld_q  <= pvld_d;
    end
  end

  assign sum_row   = sum_q;
  assign carry_row = carry_q;
  assign add_valid = pvld_q;
`else
  assign sum_row   = st4[0];
  assign carry_row = st4[1];
  assign add_valid = in_valid;
`endif

  product_t result_q, result_d;
  logic     out_valid_q, out_valid_d;

  always_comb begin
    result_d    = result_q;
    out_valid_d = add_valid;
    if (add_valid) begin
      result_d = sum_row + carry_row;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = result_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_wallace_multiplier.sv
// Self-checking bench for wallace_multiplier: scoreboard queue with due cycles, negedge monitor.
module tb_wallace_multiplier;
`ifdef WALLACE_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  // clock / reset block
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] result;
  logic        out_valid;

  always #5 clk = ~clk;

  wallace_multiplier dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .result   (result),
    .out_valid(out_valid)
  );

  // scoreboard state
  logic [15:0] exp_q[$];
  int          due_q[$];
  int          edge_cnt = 0;
  logic [15:0] hold_exp = '0;
  logic        exp_v;
  int          total = 0;
  int          bad = 0;

  // driver: present one cycle of inputs, then record what that edge should produce
  task automatic tick(input logic v, input logic [7:0] ta, input logic [7:0] tb_v, input logic r);
    int p;
    rst      = r;
    in_valid = v;
    a        = ta;
    b        = tb_v;
    @(posedge clk);
    #1;
    edge_cnt++;
    if (r) begin
      exp_q.delete();
      due_q.delete();
      hold_exp = '0;
    end else if (v) begin
      p = int'(ta) * int'(tb_v);
      exp_q.push_back(p[15:0]);
      due_q.push_back(edge_cnt + LAT - 1);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (edge_cnt > 0) begin
      exp_v = (due_q.size() > 0) && (due_q[0] == edge_cnt);
      total++;
      if (out_valid !== exp_v) begin
        bad++;
        $display("FAIL out_valid cyc=%0d got=%b want=%b", edge_cnt, out_valid, exp_v);
      end
      if (exp_v) begin
        hold_exp = exp_q.pop_front();
        void'(due_q.pop_front());
      end
      total++;
      if (result !== hold_exp) begin
        bad++;
        $display("FAIL result cyc=%0d got=%0d want=%0d", edge_cnt, result, hold_exp);
      end
    end
  end

  logic [7:0] dir_a [15] = '{8'd20, 8'd9,  8'd20, 8'd12, 8'd35, 8'd77, 8'd72,  8'd90, 8'd99,
                             8'd0,  8'd255, 8'd1, 8'd255, 8'd128, 8'd255};
  logic [7:0] dir_b [15] = '{8'd30, 8'd9,  8'd20, 8'd14, 8'd40, 8'd55, 8'd100, 8'd90, 8'd99,
                             8'd255, 8'd0, 8'd173, 8'd255, 8'd128, 8'd1};

  initial begin
    // reset with a live operand pair on the inputs
    tick(1'b1, 8'd255, 8'd255, 1'b1);
    tick(1'b1, 8'd255, 8'd255, 1'b1);

    // directed products and corners, back-to-back
    for (int i = 0; i < 15; i++) tick(1'b1, dir_a[i], dir_b[i], 1'b0);

    // hold: one product then idle cycles with random operands
    tick(1'b1, 8'd35, 8'd40, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 8'($urandom), 8'($urandom), 1'b0);

    // mid-stream reset on the cycle the second pair is accepted
    tick(1'b1, 8'd77, 8'd55, 1'b0);
    tick(1'b1, 8'd72, 8'd100, 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b0, 8'($urandom), 8'($urandom), 1'b0);

    // random traffic with gaps
    for (int i = 0; i < 400; i++)
      tick(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'b0);

    // exhaustive stream
    for (int i = 0; i < 65536; i++) tick(1'b1, 8'(i >> 8), 8'(i), 1'b0);

    for (int i = 0; i < 4; i++) tick(1'b0, 8'($urandom), 8'($urandom), 1'b0);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
